fir_mac_seq: RTL and testbench
==============================

# fir_mac_seq

Time-multiplexed FIR controller that shares one registered signed multiplier across all taps of an NUM_TAPS-tap filter. It accepts one input sample per handshake and stores it in a circular delay line. It then sequences NUM_TAPS multiply-accumulate operations through the multiplier and presents the full-precision filter output on a valid/ready port. It sits between the sample source and downstream decimation/formatting logic, replacing NUM_TAPS parallel multipliers with one.

## Interface
- DATA_WIDTH, 16, signed sample width
- COEF_WIDTH, 16, signed coefficient width
- NUM_TAPS, 8, filter length; power of two, ≥ 2
- ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+$clog2(NUM_TAPS), accumulator/result width
- clk_i  in  1  single clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush: zero delay line and pointer, abort any operation
- sample_valid_i  in  1  input sample valid
- sample_i  in  DATA_WIDTH  signed input sample
- sample_ready_o  out  1  block can accept a sample (high only in IDLE)
- coef_addr_o  out  $clog2(NUM_TAPS)  tap index to external coefficient table
- coef_i  in  COEF_WIDTH  signed coefficient h[coef_addr_o], combinational same-cycle read
- result_o  out  ACC_WIDTH  signed filter output y[n]
- result_valid_o  out  1  result_o valid
- result_ready_i  in  1  downstream accepts result
- busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, MAC, DRAIN, OUT.
- IDLE: sample_ready_o=1. On sample_valid_i&&sample_ready_o, write sample_i to buf[wr_ptr], latch base=wr_ptr, increment wr_ptr mod NUM_TAPS, clear accumulator, set k=0, go to MAC.
- MAC: issue one tap per cycle. Present coef_addr_o=k. Feed multiplier with buf[(base−k) mod NUM_TAPS] and coef_i. After k=NUM_TAPS−1, go to DRAIN.
- Accumulate: acc += product in every cycle where the multiplier output corresponds to an issued tap, i.e. the cycle after each issue. Track this with a 1-bit in-flight flag.
- DRAIN: one cycle to add the last product, then load result_o=acc and go to OUT.
- OUT: result_valid_o=1 and result_o is held stable. On result_ready_i, go to IDLE.
- Arithmetic: full signed precision and no rounding. Products are sign-extended to ACC_WIDTH. Overflow is impossible by width choice.
- Wrap-around: wr_ptr and the tap index wrap modulo NUM_TAPS. The initial delay-line contents after reset or clear are zero.
- clear_i has priority over every other event, including a same-cycle input or output handshake. It zeroes buf, wr_ptr, acc, result_o and result_valid_o, and forces IDLE. No result is emitted for an aborted sample.
- rst_ni asserted mid-operation: all state returns to reset values immediately (asynchronous). The in-flight product is discarded.
- sample_valid_i outside IDLE is ignored; the source must hold it until ready.

## Timing
- Reset values: sample_ready_o=1, result_valid_o=0, result_o=0, coef_addr_o=0, busy_o=0. State is IDLE, wr_ptr=0, buf all zero.
- Input handshake in cycle T, then:
  - Taps 0..NUM_TAPS−1 are issued in cycles T+1..T+NUM_TAPS.
  - Products are added in cycles T+2..T+NUM_TAPS+1 (DRAIN = T+NUM_TAPS+1).
  - result_valid_o rises at T+NUM_TAPS+2.
- coef_addr_o changes only on clock edges. It is 0 outside MAC.
- Minimum sample period is NUM_TAPS+3 cycles when result_ready_i is held high (11 cycles for NUM_TAPS=8).
- Output backpressure stalls the block in OUT. sample_ready_o stays low until the cycle after the result handshake.

## Structure
- Shared package/header fir_pkg: FSM state encodings (IDLE=0, MAC=1, DRAIN=2, OUT=3) and the clog2 helper used for ACC_WIDTH and the pointer widths.
- One sub-module: the team's existing registered signed multiplier, mult_reg (1-cycle latency), instantiated with IN0_WIDTH=DATA_WIDTH and IN1_WIDTH=COEF_WIDTH.
- The delay line, pointers, accumulator and FSM live in fir_mac_seq itself.

## Test plan
- Impulse, NUM_TAPS=8, h={1,2,3,4,5,6,7,8}: input 1 then seven 0s, then one more 0 → outputs 1,2,3,4,5,6,7,8, then 0. Check the first result_valid_o rises exactly 10 cycles after the input handshake.
- Extreme values: all samples −32768, all h=−32768, after 8 inputs → result_o = 8·2^30 = 8589934592. Also check there is no sign error in the 35-bit result.
- Backpressure: hold result_ready_i low for 5 cycles in OUT → result_o stable, result_valid_o=1, sample_ready_o=0 throughout; a sample offered meanwhile is not accepted.
- clear_i asserted during MAC at k=3 → next cycle shows IDLE, result_valid_o=0, busy_o=0, and no result for that sample. A following impulse reproduces the first scenario exactly.
- rst_ni pulsed low during DRAIN → all outputs at reset values immediately. After release, the first accepted sample 5 with h[0]=1 and the rest 0 gives result_o=5.
- Simultaneous clear_i with sample_valid_i in IDLE → sample not stored, and the next result reflects only later samples.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR: FSM state encoding and
// a constant-foldable log2 helper used to size pointers and the accumulator.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fir_state_e;

    // Ceiling log2, usable in parameter and port declarations.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_reg.sv
// Registered signed multiplier with one cycle of latency. The product is
// kept at full precision (IN0_WIDTH + IN1_WIDTH bits).
module mult_reg #(
    parameter int IN0_WIDTH = 16,
    parameter int IN1_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [IN0_WIDTH-1:0]           a_i,
    input  logic [IN1_WIDTH-1:0]           b_i,
    output logic [IN0_WIDTH+IN1_WIDTH-1:0] p_o
);

    localparam int P_W = IN0_WIDTH + IN1_WIDTH;

    logic signed [P_W-1:0] p_q;

    // Register the signed product; operands are sign-extended to the product width first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q <= '0;
        end else begin
            p_q <= P_W'($signed(a_i)) * P_W'($signed(b_i));
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one registered multiplier is shared across all taps.
// Each accepted sample is written into a circular delay line, then NUM_TAPS
// taps are issued one per cycle; products land one cycle later and are
// accumulated, and the full-precision sum is held on a valid/ready port.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 8,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + clog2(NUM_TAPS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       sample_valid_i,
    input  logic [DATA_WIDTH-1:0]      sample_i,
    output logic                       sample_ready_o,
    output logic [clog2(NUM_TAPS)-1:0] coef_addr_o,
    input  logic [COEF_WIDTH-1:0]      coef_i,
    output logic [ACC_WIDTH-1:0]       result_o,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic                       busy_o
);

    localparam int PTR_W  = clog2(NUM_TAPS);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

    fir_state_e                   state_q, state_d;
    logic        [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic        [PTR_W-1:0]      base_q, base_d;
    logic        [PTR_W-1:0]      k_q, k_d;
    logic        [PTR_W-1:0]      rd_idx;
    logic                         inflight_q, inflight_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]  result_q, result_d;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic        [PROD_W-1:0]     prod;
    logic signed [DATA_WIDTH-1:0] dly_q [NUM_TAPS];
    logic                         dly_we;
    logic                         dly_clr;

    // Newest sample sits at base; tap k reads k samples back, wrapping naturally in PTR_W bits.
    assign rd_idx = base_q - k_q;

    mult_reg #(
        .IN0_WIDTH(DATA_WIDTH),
        .IN1_WIDTH(COEF_WIDTH)
    ) u_mult (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .a_i   (dly_q[rd_idx]),
        .b_i   (coef_i),
        .p_o   (prod)
    );

    assign prod_ext       = ACC_WIDTH'($signed(prod));
    assign coef_addr_o    = k_q;
    assign sample_ready_o = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign result_valid_o = (state_q == OUT);
    assign result_o       = result_q;

    // Next-state and datapath control; clear_i overrides every other event.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        base_d     = base_q;
        k_d        = k_q;
        inflight_d = 1'b0;
        acc_d      = acc_q;
        result_d   = result_q;
        dly_we     = 1'b0;
        dly_clr    = 1'b0;

        // The multiplier output belongs to the tap issued in the previous cycle.
        if (inflight_q) acc_d = acc_q + prod_ext;

        case (state_q)
            IDLE: begin
                if (sample_valid_i) begin
                    dly_we   = 1'b1;
                    base_d   = wr_ptr_q;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    acc_d    = '0;
                    k_d      = '0;
                    state_d  = MAC;
                end
            end
            MAC: begin
                inflight_d = 1'b1;
                // k wraps back to 0 after the last tap, so coef_addr_o is 0 outside MAC.
                k_d        = k_q + PTR_W'(1);
                if (k_q == PTR_W'(NUM_TAPS - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                result_d = acc_d;
                state_d  = OUT;
            end
            OUT: begin
                if (result_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            base_d     = '0;
            k_d        = '0;
            inflight_d = 1'b0;
            acc_d      = '0;
            result_d   = '0;
            dly_we     = 1'b0;
            dly_clr    = 1'b1;
        end
    end

    // FSM state, pointers, in-flight flag, accumulator and held result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            base_q     <= '0;
            k_q        <= '0;
            inflight_q <= 1'b0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            base_q     <= base_d;
            k_q        <= k_d;
            inflight_q <= inflight_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
        end
    end

    // Circular delay line: zeroed on reset or clear, written on an accepted sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_TAPS; i++) dly_q[i] <= '0;
        end else if (dly_clr) begin
            for (int i = 0; i < NUM_TAPS; i++) dly_q[i] <= '0;
        end else if (dly_we) begin
            dly_q[wr_ptr_q] <= sample_i;
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: directed scenarios plus randomized traffic, with a
// scoreboard fed by a convolution reference model and drained by a monitor.
module tb_fir_mac_seq;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NT = 8;
    localparam int AW = 35;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_i = 1'b0;
    logic          sample_valid_i = 1'b0;
    logic [DW-1:0] sample_i = '0;
    logic          sample_ready_o;
    logic [2:0]    coef_addr_o;
    logic [CW-1:0] coef_i;
    logic [AW-1:0] result_o;
    logic          result_valid_o;
    logic          result_ready_i = 1'b1;
    logic          busy_o;

    logic [CW-1:0]        h [NT];
    logic signed [DW-1:0] hist [NT];
    longint               exp_q [$];
    int                   checks = 0;
    int                   failures = 0;
    int                   cyc = 0;
    logic                 done = 1'b0;

    fir_mac_seq #(
        .DATA_WIDTH(DW),
        .COEF_WIDTH(CW),
        .NUM_TAPS  (NT),
        .ACC_WIDTH (AW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear_i),
        .sample_valid_i(sample_valid_i),
        .sample_i      (sample_i),
        .sample_ready_o(sample_ready_o),
        .coef_addr_o   (coef_addr_o),
        .coef_i        (coef_i),
        .result_o      (result_o),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .busy_o        (busy_o)
    );

    // Coefficient table with combinational read
    assign coef_i = h[coef_addr_o];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint res_val();
        return longint'($signed(result_o));
    endfunction

    // Reference model: y[n] = sum_k h[k] * x[n-k], history zero after reset/clear
    task automatic model_clear();
        for (int k = 0; k < NT; k++) hist[k] = '0;
    endtask

    task automatic model_push(input logic [DW-1:0] x);
        longint sum;
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = $signed(x);
        sum = 0;
        for (int k = 0; k < NT; k++) sum += longint'($signed(hist[k])) * longint'($signed(h[k]));
        exp_q.push_back(sum);
    endtask

    task automatic set_ramp_coefs();
        for (int k = 0; k < NT; k++) h[k] = 16'(k + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sample_ready"}, sample_ready_o, 1);
        check({tag, "_result_valid"}, result_valid_o, 0);
        check({tag, "_result"}, res_val(), 0);
        check({tag, "_coef_addr"}, coef_addr_o, 0);
        check({tag, "_busy"}, busy_o, 0);
    endtask

    // Offer one sample and wait (bounded) for it to be accepted
    task automatic send(input logic [DW-1:0] x, output int hs);
        int n;
        n = 0;
        hs = 0;
        @(posedge clk);
        #1;
        sample_i = x;
        sample_valid_i = 1'b1;
        @(negedge clk);
        while (!sample_ready_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready_o) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got ready=0 required ready=1");
            sample_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            sample_valid_i = 1'b0;
            hs = cyc;
            model_push(x);
        end
    endtask

    task automatic wait_result(output longint r);
        int n;
        n = 0;
        @(negedge clk);
        while (!result_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid_o) begin
            checks++;
            failures++;
            $display("FAIL wait_result: got valid=0 required valid=1");
        end
        r = res_val();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy_o) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got pending=%0d busy=%0d required 0 0", exp_q.size(), busy_o);
        end
    endtask

    task automatic wait_addr(input logic [2:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (coef_addr_o != a && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_coef_addr", coef_addr_o, a);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        model_clear();
        exp_q.delete();
    endtask

    // Impulse then zeros; also measures latency and back-to-back sample period
    task automatic run_impulse(input string tag);
        int t0, t1, t2, n;
        send(1, t0);
        n = 0;
        while (!result_valid_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency_cycles"}, n + 1, 10);
        send(0, t1);
        send(0, t2);
        check({tag, "_sample_period"}, t2 - t1, 11);
        for (int i = 0; i < 6; i++) send(0, t0);
        wait_idle();
    endtask

    // Monitor: pop and compare on every result handshake
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && result_valid_o && result_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0d required no result", res_val());
                end else begin
                    check("result", res_val(), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int     t;
        longint r, held;

        set_ramp_coefs();
        model_clear();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Impulse response through the ramp coefficients
        run_impulse("impulse1");

        // Output backpressure
        result_ready_i = 1'b0;
        send(16'hFFFB, t);
        wait_result(held);
        sample_i = 16'd123;
        sample_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", result_valid_o, 1);
            check("bp_hold", res_val(), held);
            check("bp_sample_ready", sample_ready_o, 0);
        end
        @(posedge clk);
        #1;
        sample_valid_i = 1'b0;
        result_ready_i = 1'b1;
        send(0, t);
        wait_idle();

        // Extreme values
        do_clear();
        for (int k = 0; k < NT; k++) h[k] = 16'h8000;
        for (int i = 0; i < NT; i++) send(16'h8000, t);
        wait_result(r);
        check("extreme_value", r, 64'sd8589934592);
        check("extreme_positive", longint'(r > 0), 1);
        wait_idle();

        // Clear during MAC at k=3
        set_ramp_coefs();
        send(1, t);
        wait_addr(3'd3);
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        model_clear();
        exp_q.delete();
        check("clr_sample_ready", sample_ready_o, 1);
        check("clr_result_valid", result_valid_o, 0);
        check("clr_busy", busy_o, 0);
        check("clr_coef_addr", coef_addr_o, 0);
        repeat (12) @(negedge clk);
        run_impulse("impulse2");

        // Asynchronous reset during DRAIN
        send(7, t);
        wait_addr(3'd7);
        @(negedge clk);
        check("drain_busy", busy_o, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NT; k++) h[k] = (k == 0) ? 16'd1 : 16'd0;
        send(5, t);
        wait_result(r);
        check("post_reset_result", r, 5);
        wait_idle();

        // Clear coincident with an input handshake in IDLE
        set_ramp_coefs();
        send(3, t);
        wait_idle();
        @(negedge clk);
        sample_i = 16'd99;
        sample_valid_i = 1'b1;
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        sample_valid_i = 1'b0;
        model_clear();
        exp_q.delete();
        check("clr_vs_sample_busy", busy_o, 0);
        check("clr_vs_sample_ready", sample_ready_o, 1);
        send(2, t);
        wait_idle();

        // Randomized samples, coefficients and output backpressure
        for (int k = 0; k < NT; k++) h[k] = 16'($urandom);
        fork
            begin
                int tr;
                for (int i = 0; i < 30; i++) begin
                    send(16'($urandom), tr);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    result_ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk);
        #1;
        result_ready_i = 1'b1;
        wait_idle();

        check("pending_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
